mux2_rr_arbiter: RTL and testbench
==================================

# mux2_rr_arbiter

Two-requester round-robin arbiter and sequencer for the shared 2:1 logic mux path. It decides which of two requesters owns the mux each cycle, and drives the mux select (`sel`, wired to the mux `c` input). It transfers the granted requester's data through a one-entry registered output stage with valid/ready handshaking. A hold limit bounds how many consecutive beats one requester may take while the other is waiting.

## Interface
- `DATA_W`, default 8: width of each requester's data and of `out_data`.
- `MAX_HOLD`, default 4: maximum consecutive accepted beats per grant while the other side is requesting; legal values are ≥1.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `req0`  in  1: requester 0 valid; `data0` is meaningful while high.
- `data0`  in  DATA_W: requester 0 payload.
- `ready0`  out  1: requester 0 beat accepted this cycle when `req0 & ready0`.
- `req1`, `data1`, `ready1`: same definitions, for requester 1.
- `out_valid`  out  1: output register holds a beat.
- `out_data`  out  DATA_W: output payload.
- `out_ready`  in  1: downstream accepts when `out_valid & out_ready`.
- `sel`  out  1: mux select; 1 when in GRANT1, otherwise 0.
- `grant0`, `grant1`  out  1: one-hot state indication; both are low in IDLE.

## Operation
- **States:**
  - IDLE (reset state).
  - GRANT0.
  - GRANT1.
- **Priority pointer:**
  - Reset value is 0, meaning requester 0 wins a tie.
  - On leaving GRANTn, the pointer moves to the other requester.
- **From IDLE:**
  - Only reqN high → GRANTN.
  - Both high → the requester indicated by the pointer.
  - Neither → stay in IDLE.
- **Internal signals:**
  - `space = !out_valid | out_ready`.
  - `readyN = grantN & space`.
  - `accept = reqN & readyN` for the granted N.
- **On accept:**
  - `out_data` ← `dataN`.
  - `out_valid` ← 1.
  - Hold count +1.
- **Output drain:** on `out_valid & out_ready` with no accept, `out_valid` ← 0.
- **In GRANTn, next state:**
  - reqN low → the other side if it is requesting, else IDLE.
  - Accept that brings the hold count to MAX_HOLD, with the other side requesting → the other side.
  - Hold count reaches MAX_HOLD with the other side idle → stay in GRANTn and saturate the count at MAX_HOLD.
  - Otherwise → stay.
- **Hold count:**
  - Width is `$clog2(MAX_HOLD+1)`.
  - Cleared on every state change and in IDLE.
- **Switching:** a grant switch goes directly GRANT0↔GRANT1 with no IDLE bubble.
- **Requester rule:** keep `reqN`/`dataN` stable until accepted. Dropping `reqN` before acceptance releases the grant; this is not an error.

## Timing
- **Reset values:**
  - `out_valid`, `ready0`, `ready1`, `grant0`, `grant1`, `sel` are 0.
  - `out_data` is 0.
  - State is IDLE, pointer is 0, hold count is 0.
- **Latency:** `reqN` rising in IDLE at cycle 0 → `grantN`/`readyN` high in cycle 1 → `out_valid` high in cycle 2, provided `out_ready` holds.
- **Throughput:** back-to-back beats at 1 per cycle while `out_ready` is high.
- **Output stall:** with `out_ready` low and `out_valid` high, `readyN` = 0 and the output register holds its value. The state may still change on a req drop.
- **Simultaneous output accept and drain:** the register is overwritten and `out_valid` stays 1.
- **Outputs are combinational from state:** `sel`, `grant*`, `ready*`. `sel` changes only on a clock edge.
- **Asynchronous reset mid-transfer:** all registers clear immediately and any beat held in the output register is discarded. After `rst_n` rises, the first possible grant is one cycle later.

## Test plan
- **Reset:** assert `rst_n`=0 mid-burst with `out_valid`=1 → `out_valid`, `grant*`, `sel` drop to 0 without a clock edge. After release, `req0`=1 gives `grant0` after 1 cycle.
- **Single requester:**
  - Stimulus: `req0`=1, data 0x11,0x22,0x33, `out_ready`=1.
  - Required: `out_data` shows 0x11/0x22/0x33 on consecutive cycles starting cycle 2, and `sel`=0 throughout.
- **Tie from IDLE:** `req0`=`req1`=1 after reset → GRANT0 first. After requester 0's req drops → GRANT1 with `sel`=1. The next tie goes to requester 0.
- **Hold limit:**
  - Stimulus: MAX_HOLD=4, both requesting continuously, `out_ready`=1.
  - Required: beats alternate in groups of 4 (0,0,0,0,1,1,1,1,0…) with no idle cycle at switches.
- **Backpressure:**
  - Stimulus: `out_ready`=0 for 3 cycles with `out_valid`=1 holding 0xA5.
  - Required: `out_data` stays 0xA5, `ready*` stays 0, and no beat is lost or duplicated once `out_ready` returns to 1.
- **Hold saturation:** requester 1 alone sends 10 beats with MAX_HOLD=4 → stays in GRANT1 for all 10 beats. Requester 0 rising then waits at most until the grant switch that follows the next accepted beat.

Source files
------------

// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter feeding a one-entry registered output stage; drives the shared 2:1 mux select.
// Latency: req in IDLE -> grant/ready next cycle -> out_valid the cycle after; then 1 beat/cycle.
// Backpressure: readyN drops whenever the output register is full and out_ready is low; the held beat is never lost.
module mux2_rr_arbiter #(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [DATA_W-1:0] data0,
  output logic              ready0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data1,
  output logic              ready1,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              sel,
  output logic              grant0,
  output logic              grant1
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX   = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W:0]   HOLD_LIMIT = (HOLD_W + 1)'(MAX_HOLD);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                ptr_q, ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;

  logic                gnt0, gnt1;
  logic                space;
  logic                rdy0, rdy1;
  logic                accept;
  logic [DATA_W-1:0]   acc_data;
  logic [HOLD_W:0]     hold_inc;
  logic                hold_at_limit;

  // State register: FSM state, tie-break pointer and consecutive-beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  // Output comb: grants, selects and readies are pure functions of the registered state.
  always_comb begin
    gnt0     = (state_q == ST_GRANT0);
    gnt1     = (state_q == ST_GRANT1);
    space    = !out_valid_q || out_ready;
    rdy0     = gnt0 && space;
    rdy1     = gnt1 && space;
    accept   = (req0 && rdy0) || (req1 && rdy1);
    acc_data = gnt1 ? data1 : data0;
  end

  // Next-state comb: round-robin choice from IDLE, release on req drop, forced hand-over at the hold limit.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    hold_inc      = {1'b0, hold_q} + 1'b1;
    // True when this accept is the MAX_HOLD-th one (or later, once saturated).
    hold_at_limit = (hold_inc >= HOLD_LIMIT);
    case (state_q)
      ST_IDLE: begin
        if (req0 && (!req1 || !ptr_q)) begin
          state_d = ST_GRANT0;
        end else if (req1) begin
          state_d = ST_GRANT1;
        end
      end
      ST_GRANT0: begin
        if (!req0) begin
          state_d = req1 ? ST_GRANT1 : ST_IDLE;
        end else if (accept && hold_at_limit && req1) begin
          state_d = ST_GRANT1;
        end
      end
      ST_GRANT1: begin
        if (!req1) begin
          state_d = req0 ? ST_GRANT0 : ST_IDLE;
        end else if (accept && hold_at_limit && req0) begin
          state_d = ST_GRANT0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Leaving a grant hands tie priority to the other requester.
    if ((state_q == ST_GRANT0) && (state_d != ST_GRANT0)) begin
      ptr_d = 1'b1;
    end else if ((state_q == ST_GRANT1) && (state_d != ST_GRANT1)) begin
      ptr_d = 1'b0;
    end
  end

  // Hold counter: cleared on any state change or in IDLE, otherwise counts accepts and saturates at MAX_HOLD.
  always_comb begin
    hold_d = hold_q;
    if ((state_d != state_q) || (state_q == ST_IDLE)) begin
      hold_d = '0;
    end else if (accept && (hold_q != HOLD_MAX)) begin
      hold_d = hold_inc[HOLD_W-1:0];
    end
  end

  // Output stage comb: load on accept (overwriting a beat draining this cycle), clear on drain alone.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = acc_data;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output stage register; reset discards any held beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign grant0    = gnt0;
  assign grant1    = gnt1;
  assign sel       = gnt1;
  assign ready0    = rdy0;
  assign ready1    = rdy1;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Self-checking bench for mux2_rr_arbiter: vector table, directed corner sequences and random traffic.
// Inputs change on the falling edge; outputs are sampled 1ns later, well away from the rising edge.
// A cycle-level ownership model plus a beat scoreboard supplies every expected value.
module tb_mux2_rr_arbiter;

  localparam int DATA_W   = 8;
  localparam int MAX_HOLD = 4;

  logic              clk;
  logic              rst_n;
  logic [1:0]        req_v;
  logic [DATA_W-1:0] data_v [2];
  logic              out_ready;
  logic              ready0, ready1, out_valid, sel, grant0, grant1;
  logic [DATA_W-1:0] out_data;

  mux2_rr_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req_v[0]),
    .data0     (data_v[0]),
    .ready0    (ready0),
    .req1      (req_v[1]),
    .data1     (data_v[1]),
    .ready1    (ready1),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .sel       (sel),
    .grant0    (grant0),
    .grant1    (grant1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // Reference model: who owns the mux, whose turn a tie is, how long the current run is,
  // and the content of the output register; plus the queue of beats still owed downstream.
  int                m_owner;
  int                m_ptr;
  int                m_streak;
  bit                m_oval;
  logic [DATA_W-1:0] m_odat;
  bit                m_acc [2];
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] delivered [$];

  // Snapshot of the last sampled cycle.
  logic [13:0] s_out;
  int          s_acc_id;

  typedef struct {
    logic              r0;
    logic              r1;
    logic [DATA_W-1:0] d0;
    logic [DATA_W-1:0] d1;
    logic              ord;
    logic [5:0]        flags;   // grant0, grant1, sel, ready0, ready1, out_valid
    logic [DATA_W-1:0] od;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [13:0] dut_vec();
    return {grant0, grant1, sel, ready0, ready1, out_valid, out_data};
  endfunction

  task automatic model_reset();
    m_owner  = -1;
    m_ptr    = 0;
    m_streak = 0;
    m_oval   = 0;
    m_odat   = '0;
    m_acc[0] = 0;
    m_acc[1] = 0;
    exp_q.delete();
    delivered.delete();
  endtask

  // One clock cycle: sample, compare with the model, advance the model, move to the next falling edge.
  task automatic cycle();
    bit          space;
    bit          acc;
    bit          leave;
    int          me;
    int          other;
    int          nxt;
    logic [13:0] exp;
    #1;
    s_out    = dut_vec();
    s_acc_id = (ready0 && req_v[0]) ? 0 : ((ready1 && req_v[1]) ? 1 : -1);
    space    = !m_oval || out_ready;
    exp      = {m_owner == 0, m_owner == 1, m_owner == 1,
                (m_owner == 0) && space, (m_owner == 1) && space, m_oval, m_odat};
    chk("cycle_outputs", s_out, exp);
    if (out_valid && out_ready) begin
      delivered.push_back(out_data);
      if (exp_q.size() == 0) begin
        chk("scoreboard_unexpected_beat", {24'd0, out_data}, 32'hFFFF_FFFF);
      end else begin
        chk("scoreboard_data", out_data, exp_q.pop_front());
      end
    end
    acc = 0;
    if (m_owner >= 0) acc = req_v[m_owner] && space;
    m_acc[0] = acc && (m_owner == 0);
    m_acc[1] = acc && (m_owner == 1);
    if (acc) begin
      exp_q.push_back(data_v[m_owner]);
      m_oval = 1;
      m_odat = data_v[m_owner];
    end else if (m_oval && out_ready) begin
      m_oval = 0;
    end
    if (m_owner < 0) begin
      if (req_v[0] && req_v[1]) m_owner = m_ptr;
      else if (req_v[0])        m_owner = 0;
      else if (req_v[1])        m_owner = 1;
      m_streak = 0;
    end else begin
      me    = m_owner;
      other = 1 - m_owner;
      leave = 0;
      nxt   = -1;
      if (!req_v[me]) begin
        leave = 1;
        nxt   = req_v[other] ? other : -1;
      end else if (acc) begin
        m_streak = (m_streak + 1 > MAX_HOLD) ? MAX_HOLD : m_streak + 1;
        if (m_streak == MAX_HOLD && req_v[other]) begin
          leave = 1;
          nxt   = other;
        end
      end
      if (leave) begin
        m_ptr    = other;
        m_owner  = nxt;
        m_streak = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    req_v     = 2'b00;
    data_v[0] = '0;
    data_v[1] = '0;
    out_ready = 1'b0;
  endtask

  // Reset across one rising edge, check every output is cleared, release on a falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    #1;
    chk("reset_state", dut_vec(), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    model_reset();
    clear_inputs();

    // Vector table: single requester 11/22/33, release to IDLE, pointer-driven tie, switch on req drop.
    vecs[0]  = '{1'b1, 1'b0, 8'h11, 8'h00, 1'b1, 6'b000000, 8'h00};
    vecs[1]  = '{1'b1, 1'b0, 8'h11, 8'h00, 1'b1, 6'b100100, 8'h00};
    vecs[2]  = '{1'b1, 1'b0, 8'h22, 8'h00, 1'b1, 6'b100101, 8'h11};
    vecs[3]  = '{1'b1, 1'b0, 8'h33, 8'h00, 1'b1, 6'b100101, 8'h22};
    vecs[4]  = '{1'b0, 1'b0, 8'h33, 8'h00, 1'b1, 6'b100101, 8'h33};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 6'b000000, 8'h33};
    vecs[6]  = '{1'b1, 1'b1, 8'h44, 8'h55, 1'b1, 6'b000000, 8'h33};
    vecs[7]  = '{1'b1, 1'b1, 8'h44, 8'h55, 1'b1, 6'b011010, 8'h33};
    vecs[8]  = '{1'b1, 1'b0, 8'h44, 8'h55, 1'b1, 6'b011011, 8'h55};
    vecs[9]  = '{1'b1, 1'b0, 8'h44, 8'h00, 1'b1, 6'b100100, 8'h55};
    vecs[10] = '{1'b0, 1'b0, 8'h44, 8'h00, 1'b1, 6'b100101, 8'h44};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 6'b000000, 8'h44};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      req_v     = {vecs[i].r1, vecs[i].r0};
      data_v[0] = vecs[i].d0;
      data_v[1] = vecs[i].d1;
      out_ready = vecs[i].ord;
      cycle();
      chk($sformatf("vector_%0d", i), s_out, {vecs[i].flags, vecs[i].od});
    end

    // Tie from IDLE after reset goes to requester 0; its drop hands over to 1; next tie back to 0.
    do_reset();
    req_v = 2'b11; data_v[0] = 8'h01; data_v[1] = 8'h02; out_ready = 1'b1;
    cycle();
    cycle();
    chk("tie_first_grant0", s_out[13], 32'd1);
    req_v = 2'b10;
    cycle();
    cycle();
    chk("tie_then_grant1_sel", {s_out[12], s_out[11]}, 32'd3);
    req_v = 2'b00;
    cycle();
    req_v = 2'b11; data_v[0] = 8'h03; data_v[1] = 8'h04;
    cycle();
    cycle();
    chk("tie_next_to_0", s_out[13], 32'd1);
    req_v = 2'b00;
    cycle();
    cycle();

    // Hold limit: both requesting, groups of MAX_HOLD beats alternating with no idle cycle.
    do_reset();
    req_v = 2'b11; out_ready = 1'b1;
    for (int c = 0; c < 18; c++) begin
      data_v[0] = 8'(c);
      data_v[1] = 8'(8'h80 + c);
      cycle();
      if (c >= 1) chk($sformatf("hold_group_c%0d", c), s_acc_id, ((c - 1) / MAX_HOLD) % 2);
    end
    req_v = 2'b00;
    cycle();
    cycle();

    // Backpressure: 0xA5 held through a 3-cycle stall, next beat waits, nothing lost or doubled.
    do_reset();
    req_v = 2'b01; data_v[0] = 8'hA5; out_ready = 1'b1;
    cycle();
    cycle();
    data_v[0] = 8'hB6; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk($sformatf("stall_hold_%0d", k), {s_out[10], s_out[8], s_out[7:0]}, {2'b01, 8'hA5});
    end
    out_ready = 1'b1;
    cycle();
    req_v = 2'b00;
    cycle();
    cycle();
    chk("stall_beat_count", delivered.size(), 32'd2);
    if (delivered.size() == 2) begin
      chk("stall_beat0", delivered[0], 32'hA5);
      chk("stall_beat1", delivered[1], 32'hB6);
    end

    // Hold saturation: requester 1 alone for 10 beats keeps the grant; 0 then gets it after one more beat.
    do_reset();
    req_v = 2'b10; out_ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      data_v[1] = 8'(8'h40 + c);
      cycle();
      if (c >= 1) chk($sformatf("sat_grant1_c%0d", c), {s_out[12], s_acc_id == 1}, 32'd3);
    end
    req_v = 2'b11; data_v[0] = 8'h99; data_v[1] = 8'h4B;
    cycle();
    chk("sat_last_beat_grant1", s_acc_id, 32'd1);
    data_v[1] = 8'h4C;
    cycle();
    chk("sat_switch_grant0", s_out[13], 32'd1);
    req_v = 2'b00;
    cycle();
    cycle();

    // Asynchronous reset mid-burst clears outputs with no clock edge; first grant one cycle after release.
    do_reset();
    req_v = 2'b01; data_v[0] = 8'h5A; out_ready = 1'b1;
    cycle();
    cycle();
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_clear", {out_valid, grant0, grant1, sel, ready0, ready1}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    req_v = 2'b01; data_v[0] = 8'h66; out_ready = 1'b1;
    cycle();
    chk("post_reset_idle", s_out[13], 32'd0);
    cycle();
    chk("post_reset_grant0", s_out[13], 32'd1);
    req_v = 2'b00;
    cycle();
    cycle();

    // Random traffic honouring the requester rule, with occasional early req drops.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      for (int n = 0; n < 2; n++) begin
        if (req_v[n] && !m_acc[n]) begin
          if ($urandom_range(0, 15) == 0) req_v[n] = 1'b0;
        end else begin
          req_v[n]  = ($urandom_range(0, 2) != 0);
          data_v[n] = 8'($urandom);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    req_v = 2'b00; out_ready = 1'b1;
    cycle();
    cycle();
    cycle();
    chk("random_all_beats_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
